// File: rtl/duck_pkg.sv
// Shared constants, game-phase encodings and a saturating-add helper for the shot tracker.
package duck_pkg;

  parameter int unsigned SHOTS_PER_BIRD = 3;
  parameter int unsigned BIRDS_PER_GAME = 10;
  parameter int unsigned POINTS_PER_HIT = 500;

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_PREP  = 2'b01,
    ST_PLAY  = 2'b10,
    ST_DONE  = 2'b11
  } phase_e;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector. History resets high so a level held through reset is not an edge.
module edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= d_i;
    end
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/shot_tracker.sv
// Per-bird shot, hit and score bookkeeping for the duck-hunt game controller.
// Optional: define FIRST_SHOT_BONUS_EN to double the points for a first-shot hit.
module shot_tracker
  import duck_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        trigger,
  input  logic        hit,
  input  logic [1:0]  state,
  input  logic        reset_shots,
  input  logic        reset_score,
  input  logic        reset_birds,
  output logic        no_shots_left,
  output logic        bird_shot,
  output logic        game_over,
  output logic [1:0]  shots_left,
  output logic [3:0]  birds_done,
  output logic [15:0] score,
  output logic [9:0]  hits_mask
);

  localparam logic [1:0] ShotsInit = 2'(SHOTS_PER_BIRD);
  localparam logic [3:0] BirdsMax  = 4'(BIRDS_PER_GAME);
  localparam logic [15:0] Points   = 16'(POINTS_PER_HIT);

  logic [1:0]  shots_q, shots_d;
  logic        bird_shot_q, bird_shot_d;
  logic [3:0]  birds_q, birds_d;
  logic [15:0] score_q, score_d;
  logic [9:0]  mask_q, mask_d;

  logic        trig_rise;
  logic        in_play;
  logic        any_clear;
  logic        shot;
  logic [15:0] pts;

  edge_detect u_trig_edge (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .d_i    (trigger),
    .rise_o (trig_rise)
  );

  assign in_play   = (state == ST_PLAY);
  assign any_clear = reset_shots | reset_score | reset_birds;
  // A clear in the same cycle wins; the edge is dropped, not queued.
  assign shot = trig_rise & in_play & (shots_q != 2'd0) & ~bird_shot_q & ~any_clear;

`ifdef FIRST_SHOT_BONUS_EN
  assign pts = (shots_q == ShotsInit) ? 16'(2 * POINTS_PER_HIT) : Points;
`else
  assign pts = Points;
`endif

  always_comb begin
    shots_d     = shots_q;
    bird_shot_d = bird_shot_q;
    birds_d     = birds_q;
    score_d     = score_q;
    mask_d      = mask_q;

    if (reset_shots) begin
      shots_d     = ShotsInit;
      bird_shot_d = 1'b0;
      if (in_play && (birds_q < BirdsMax)) begin
        birds_d = birds_q + 4'd1;
        if (bird_shot_q) begin
          mask_d = mask_q | (10'd1 << birds_q);
        end
      end
    end else if (shot) begin
      shots_d = shots_q - 2'd1;
      if (hit) begin
        bird_shot_d = 1'b1;
        score_d     = sat_add16(score_q, pts);
      end
    end

    if (reset_score) begin
      score_d = 16'd0;
    end
    if (reset_birds) begin
      birds_d = 4'd0;
      mask_d  = 10'd0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shots_q     <= ShotsInit;
      bird_shot_q <= 1'b0;
      birds_q     <= 4'd0;
      score_q     <= 16'd0;
      mask_q      <= 10'd0;
    end else begin
      shots_q     <= shots_d;
      bird_shot_q <= bird_shot_d;
      birds_q     <= birds_d;
      score_q     <= score_d;
      mask_q      <= mask_d;
    end
  end

  assign shots_left    = shots_q;
  assign bird_shot     = bird_shot_q;
  assign birds_done    = birds_q;
  assign score         = score_q;
  assign hits_mask     = mask_q;
  assign no_shots_left = (shots_q == 2'd0) & ~bird_shot_q;
  assign game_over     = (birds_q >= 4'd9);

endmodule

// File: tb/tb_shot_tracker.sv
// Self-checking bench for shot_tracker: directed scenarios plus random stimulus vs. a game model.
module tb_shot_tracker;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        trigger = 1'b0;
  logic        hit = 1'b0;
  logic [1:0]  state = 2'b00;
  logic        reset_shots = 1'b0;
  logic        reset_score = 1'b0;
  logic        reset_birds = 1'b0;
  logic        no_shots_left;
  logic        bird_shot;
  logic        game_over;
  logic [1:0]  shots_left;
  logic [3:0]  birds_done;
  logic [15:0] score;
  logic [9:0]  hits_mask;

  shot_tracker dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .trigger       (trigger),
    .hit           (hit),
    .state         (state),
    .reset_shots   (reset_shots),
    .reset_score   (reset_score),
    .reset_birds   (reset_birds),
    .no_shots_left (no_shots_left),
    .bird_shot     (bird_shot),
    .game_over     (game_over),
    .shots_left    (shots_left),
    .birds_done    (birds_done),
    .score         (score),
    .hits_mask     (hits_mask)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Game model: plain integers, one update per clock from the rules of play.
  int       m_shots, m_birds, m_score;
  bit       m_bs, m_prev;
  bit [9:0] m_mask;

`ifdef FIRST_SHOT_BONUS_EN
  localparam int FirstHitPts = 1000;
`else
  localparam int FirstHitPts = 500;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_shots = 3; m_bs = 0; m_birds = 0; m_score = 0; m_mask = '0; m_prev = 1;
  endtask

  task automatic model_clock();
    int       n_shots, n_birds, n_score, pts;
    bit       n_bs, take, play;
    bit [9:0] n_mask;
    n_shots = m_shots; n_birds = m_birds; n_score = m_score; n_bs = m_bs; n_mask = m_mask;
    play = (state == 2'b10);
    take = trigger && !m_prev && play && m_shots > 0 && !m_bs
           && !reset_shots && !reset_score && !reset_birds;
    pts = (m_shots == 3) ? FirstHitPts : 500;
    if (reset_shots) begin
      n_shots = 3;
      n_bs = 0;
      if (play && m_birds < 10) begin
        if (m_bs) n_mask[m_birds] = 1'b1;
        n_birds = m_birds + 1;
      end
    end else if (take) begin
      n_shots = m_shots - 1;
      if (hit) begin
        n_bs = 1;
        n_score = (m_score + pts > 65535) ? 65535 : m_score + pts;
      end
    end
    if (reset_score) n_score = 0;
    if (reset_birds) begin
      n_birds = 0;
      n_mask = '0;
    end
    m_prev = trigger;
    m_shots = n_shots; m_birds = n_birds; m_score = n_score; m_bs = n_bs; m_mask = n_mask;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".shots_left"}, shots_left, m_shots);
    chk({tag, ".bird_shot"}, bird_shot, m_bs);
    chk({tag, ".birds_done"}, birds_done, m_birds);
    chk({tag, ".score"}, score, m_score);
    chk({tag, ".hits_mask"}, hits_mask, m_mask);
    chk({tag, ".no_shots_left"}, no_shots_left, (m_shots == 0) && !m_bs);
    chk({tag, ".game_over"}, game_over, m_birds >= 9);
  endtask

  task automatic step(input string tag);
    @(posedge Clk);
    model_clock();
    #1;
    check_all(tag);
  endtask

  task automatic fire(input bit h, input string tag);
    hit = h; trigger = 1'b1;
    step(tag);
    hit = 1'b0; trigger = 1'b0;
    step(tag);
  endtask

  task automatic clear_shots(input logic [1:0] st, input string tag);
    state = st; reset_shots = 1'b1;
    step(tag);
    reset_shots = 1'b0; state = 2'b10;
  endtask

  initial begin
    // Trigger held through reset must not fire on release.
    trigger = 1'b1;
    model_reset();
    #12;
    check_all("reset");
    chk("reset.shots3", shots_left, 3);
    @(negedge Clk);
    Reset_n = 1'b1;
    state = 2'b10;
    step("held_through_reset");
    chk("held_through_reset.shots", shots_left, 3);
    trigger = 1'b0;
    step("idle");

    for (int i = 0; i < 3; i++) begin
      fire(1'b0, "miss");
      chk("miss.shots", shots_left, 2 - i);
    end
    chk("miss.no_shots_left", no_shots_left, 1);
    chk("miss.score", score, 0);
    fire(1'b0, "empty_mag");
    chk("empty_mag.shots", shots_left, 0);

    clear_shots(2'b01, "prep_reload");
    chk("prep_reload.birds", birds_done, 0);

    trigger = 1'b1;
    repeat (20) step("held");
    trigger = 1'b0;
    step("held");
    chk("held.one_shot", shots_left, 2);

    clear_shots(2'b01, "prep_reload2");
    fire(1'b0, "s1");
    fire(1'b0, "s2");
    fire(1'b1, "s3_hit");
    chk("last_hit.bird_shot", bird_shot, 1);
    chk("last_hit.no_shots_left", no_shots_left, 0);
    chk("last_hit.score", score, 500);
    clear_shots(2'b10, "resolve");
    chk("resolve.shots", shots_left, 3);
    chk("resolve.birds", birds_done, 1);
    chk("resolve.mask", hits_mask, 10'b1);

    reset_score = 1'b1; step("clr_score"); reset_score = 1'b0;
    fire(1'b1, "first_hit");
    chk("first_hit.score", score, FirstHitPts);
    fire(1'b1, "after_hit");
    chk("after_hit.shots", shots_left, 2);

    reset_birds = 1'b1; step("clr_birds"); reset_birds = 1'b0;
    for (int b = 0; b < 11; b++) begin
      fire(b[0], "game_bird");
      clear_shots(2'b10, "game_resolve");
      if (b == 8) chk("game_over_at9", game_over, 1);
    end
    chk("birds_sat", birds_done, 10);
    chk("game_over_end", game_over, 1);

    for (int k = 0; k < 140; k++) begin
      fire(1'b1, "sat_hit");
      clear_shots(2'b01, "sat_reload");
    end
    chk("score_sat", score, 16'hFFFF);

    clear_shots(2'b01, "pre_coinc");
    reset_shots = 1'b1; trigger = 1'b1;
    step("coincident");
    chk("coincident.shots", shots_left, 3);
    reset_shots = 1'b0; trigger = 1'b0;
    step("coincident_after");

    fire(1'b0, "pre_async");
    trigger = 1'b1;
    Reset_n = 1'b0;
    #2;
    model_reset();
    check_all("async_reset");
    chk("async_reset.shots", shots_left, 3);
    chk("async_reset.score", score, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    step("post_async");
    trigger = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      trigger     = $urandom_range(0, 1);
      hit         = $urandom_range(0, 1);
      state       = ($urandom_range(0, 3) != 0) ? 2'b10 : 2'($urandom_range(0, 3));
      reset_shots = ($urandom_range(0, 9) == 0);
      reset_score = ($urandom_range(0, 99) == 0);
      reset_birds = ($urandom_range(0, 199) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
